ps2_key_receiver: RTL and testbench

//  - Parametrised PS/2 keyboard receiver: deserialises 11-bit device-to-host frames, checks start/parity/stop, decodes E0/F0 prefixes.
//  - Outputs complete key events through a FIFO with a valid/ready interface.
//  - Sits between the board PS/2 pins and text-entry / control logic (ENTER, BACK, SPACE, ESC consumers).

---
 rtl/ps2_pkg.sv | 31 +++
 rtl/ps2_key_receiver_if.sv | 21 ++
 rtl/ps2_frame_rx.sv | 112 +++++++++++
 rtl/ps2_key_receiver.sv | 138 +++++++++++++
 tb/tb_ps2_key_receiver.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared constants and types.
// Scan-code prefixes, key codes, event layout, frame FSM states.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BACK  = 8'h66;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  localparam int BRK_BIT = 9;
  localparam int EXT_BIT = 8;

  typedef enum logic [1:0] {
    FS_IDLE,
    FS_DATA,
    FS_PARITY,
    FS_STOP
  } frame_state_t;

  // True when data plus parity bit has odd weight.
  function automatic logic odd_ok(
    input logic [7:0] d,
    input logic       p
  );
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_key_receiver_if.sv
// Key-event stream handshake.
// Master drives valid/event, slave drives ready.
interface ps2_key_receiver_if;

  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_event;

  modport master (
    output out_valid,
    output out_event,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_event,
    output out_ready
  );

endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserialiser: sync, falling-edge detect,
// 11-bit frame FSM with parity/stop check and timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_prev;
  frame_state_t           r_state;
  frame_state_t           w_state_nxt;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_to_cnt;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;
  logic                   w_to_hit;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_prev & ~w_clk_s;
  assign rx_byte = r_shift;

  // Synchronise the pins; idle-high reset avoids a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev <= w_clk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= FS_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state: walk the frame on each edge, abort on timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_to_hit = (r_state != FS_IDLE) && !w_fall &&
               (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    case (r_state)
      FS_IDLE:
        if (w_fall && !w_dat_s) w_state_nxt = FS_DATA;
      FS_DATA:
        if (w_fall && r_bit_cnt == 3'd7)
          w_state_nxt = FS_PARITY;
      FS_PARITY:
        if (w_fall) w_state_nxt = FS_STOP;
      FS_STOP:
        if (w_fall) w_state_nxt = FS_IDLE;
      default: w_state_nxt = FS_IDLE;
    endcase
    if (w_to_hit) w_state_nxt = FS_IDLE;
  end

  // Shift data, track timeout, flag good byte or error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= w_to_hit;
      if (r_state == FS_IDLE || w_fall) r_to_cnt <= '0;
      else r_to_cnt <= r_to_cnt + 1'b1;
      if (w_fall) begin
        case (r_state)
          FS_IDLE: r_bit_cnt <= '0;
          FS_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
          end
          FS_PARITY: r_par <= w_dat_s;
          FS_STOP: begin
            if (w_dat_s && odd_ok(r_shift, r_par))
              byte_valid <= 1'b1;
            else
              frame_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: prefix decode, event FIFO, error stats.
// PS2_REPEAT_FILTER_EN suppresses typematic repeat makes.
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 3,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_key_receiver_if.master out_if,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic              overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic          w_bv;
  logic [7:0]    w_byte;
  logic          w_ferr;
  logic          r_ext;
  logic          r_brk;
  logic          w_dec;
  logic          w_emit;
  logic [9:0]    w_event;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;
  logic          w_full;
  logic          w_push;
  logic          w_pop;

  ps2_frame_rx #(
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(w_bv),
    .rx_byte   (w_byte),
    .frame_err (w_ferr)
  );

  assign frame_err = w_ferr;
  assign w_dec = w_bv && w_byte != PS2_EXT &&
                 w_byte != PS2_BRK;

  // Assemble {brk, ext, code} from the pending prefix flags.
  always_comb begin
    w_event = {2'b00, w_byte};
    w_event[BRK_BIT] = r_brk;
    w_event[EXT_BIT] = r_ext;
  end

  // Prefix flags: set by E0/F0, cleared once a code is emitted.
  always_ff @(posedge clk) begin
    if (rst || w_ferr) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_bv) begin
      if (w_byte == PS2_EXT) r_ext <= 1'b1;
      else if (w_byte == PS2_BRK) r_brk <= 1'b1;
      else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic       r_held;
  logic [8:0] r_held_key;
  logic       w_same;

  assign w_same = r_held && r_held_key == {r_ext, w_byte};
  assign w_emit = w_dec && !(!r_brk && w_same);

  // Remember the held key; its release frees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_held     <= 1'b0;
      r_held_key <= '0;
    end else if (w_dec) begin
      if (!r_brk) begin
        r_held     <= 1'b1;
        r_held_key <= {r_ext, w_byte};
      end else if (w_same) begin
        r_held <= 1'b0;
      end
    end
  end
`else
  assign w_emit = w_dec;
`endif

  assign w_full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign out_if.out_valid = r_cnt != '0;
  assign w_pop  = out_if.out_valid & out_if.out_ready;
  assign w_push = w_emit && (!w_full || w_pop);
  assign out_if.out_event =
    out_if.out_valid ? r_mem[r_rd] : '0;

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= w_event;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop) r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      if (w_emit && !w_push) overflow <= 1'b1;
    end
  end

  // Saturating frame-error counter.
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else if (w_ferr && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver.
// Table vectors, corner sequences, randomized model check.
module tb_ps2_key_receiver;

  localparam int SYNC = 3;
  localparam int DEPTH = 8;
  localparam int TOC = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic frame_err;
  logic [7:0] err_cnt;
  logic overflow;

  int n_cmp = 0;
  int n_err = 0;
  int err_seen = 0;
  logic [9:0] got[$];
  logic [9:0] exp_q[$];

  ps2_key_receiver_if u_if ();

  ps2_key_receiver #(
    .SYNC_STAGES(SYNC),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT_CYC(TOC)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .out_if   (u_if),
    .frame_err(frame_err),
    .err_cnt  (err_cnt),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && u_if.out_valid && u_if.out_ready)
      got.push_back(u_if.out_event);
    if (!rst && frame_err) err_seen++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (8) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Full frame; lat = first negedge after stop edge
  // (counted from the pin) at which out_valid is 1.
  task automatic send_frame(input logic [7:0] d,
                            input bit bad_par,
                            output int lat);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~(^d) ^ bad_par);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (lat == 0 && u_if.out_valid) lat = k;
    end
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Reference model: prefix rules plus optional repeat filter.
  bit m_ext, m_brk, m_held;
  logic [8:0] m_key;

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_held = 0; m_key = '0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit keep;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      keep = 1;
`ifdef PS2_REPEAT_FILTER_EN
      if (!m_brk) begin
        if (m_held && m_key == {m_ext, b}) keep = 0;
        m_held = 1;
        m_key = {m_ext, b};
      end else if (m_held && m_key == {m_ext, b}) begin
        m_held = 0;
      end
`endif
      if (keep) exp_q.push_back({m_brk, m_ext, b});
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    send_frame(b, 0, lat);
    model_byte(b);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2;
    int n;
    logic [9:0] ev;
  } vec_t;

  vec_t tbl[6];
  int lat;
  int e0;
  logic [7:0] bs[3];
  int nexp;

  initial begin
    tbl[0] = '{8'h1C, 8'h00, 8'h00, 1, 10'h01C};
    tbl[1] = '{8'hF0, 8'h1C, 8'h00, 2, 10'h21C};
    tbl[2] = '{8'hE0, 8'h75, 8'h00, 2, 10'h175};
    tbl[3] = '{8'hE0, 8'hF0, 8'h75, 3, 10'h375};
    tbl[4] = '{8'h5A, 8'h00, 8'h00, 1, 10'h05A};
    tbl[5] = '{8'hE0, 8'hF0, 8'h76, 3, 10'h376};

    u_if.out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_event", u_if.out_event, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_errcnt", err_cnt, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Single make, latency from stop edge.
    got.delete();
    send_frame(8'h1C, 0, lat);
    chk("lat", lat, SYNC + 2);
    chk("t1_n", got.size(), 1);
    if (got.size() > 0) chk("t1_ev", got[0], 10'h01C);

    foreach (tbl[i]) begin
      got.delete();
      bs[0] = tbl[i].b0; bs[1] = tbl[i].b1;
      bs[2] = tbl[i].b2;
      for (int j = 0; j < tbl[i].n; j++)
        send_frame(bs[j], 0, lat);
      chk($sformatf("tbl%0d_n", i), got.size(), 1);
      if (got.size() > 0)
        chk($sformatf("tbl%0d_ev", i), got[0], tbl[i].ev);
    end

    // Bad parity then good byte.
    got.delete();
    e0 = err_seen;
    send_frame(8'h5A, 1, lat);
    chk("par_pulse", err_seen - e0, 1);
    chk("par_cnt", err_cnt, 1);
    chk("par_none", got.size(), 0);
    send_frame(8'h5A, 0, lat);
    chk("par_next_n", got.size(), 1);
    if (got.size() > 0) chk("par_next", got[0], 10'h05A);

    // Partial frame then timeout.
    got.delete();
    e0 = err_seen;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    repeat (TOC + 50) @(negedge clk);
    chk("to_pulse", err_seen - e0, 1);
    chk("to_cnt", err_cnt, 2);
    send_frame(8'h29, 0, lat);
    chk("to_next_n", got.size(), 1);
    if (got.size() > 0) chk("to_next", got[0], 10'h029);

    // Overflow: fill with ready low, then drain.
    got.delete();
    u_if.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++)
      send_frame(8'(i), 0, lat);
    chk("ovf_full_no", overflow, 0);
    send_frame(8'(DEPTH + 1), 0, lat);
    chk("ovf_set", overflow, 1);
    u_if.out_ready = 1'b1;
    repeat (DEPTH + 5) @(negedge clk);
    chk("ovf_n", got.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < got.size(); i++)
      chk($sformatf("ovf_ev%0d", i), got[i], 10'(i + 1));
    chk("ovf_sticky", overflow, 1);

    // Typematic repeat sequence.
    got.delete();
    send_frame(8'h1C, 0, lat);
    send_frame(8'h1C, 0, lat);
    send_frame(8'h1C, 0, lat);
    send_frame(8'hF0, 0, lat);
    send_frame(8'h1C, 0, lat);
    send_frame(8'h1C, 0, lat);
`ifdef PS2_REPEAT_FILTER_EN
    exp_q = '{10'h01C, 10'h21C, 10'h01C};
`else
    exp_q = '{10'h01C, 10'h01C, 10'h01C,
              10'h21C, 10'h01C};
`endif
    chk("rep_n", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rep%0d", i), got[i], exp_q[i]);

    // Reset mid-frame: nothing emitted, state cleared.
    got.delete();
    send_frame(8'hE0, 0, lat);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    e0 = err_seen;
    repeat (TOC + 50) @(negedge clk);
    chk("mrst_err", err_seen - e0, 0);
    chk("mrst_cnt", err_cnt, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_none", got.size(), 0);

    // Random key events against the model.
    model_reset();
    got.delete();
    for (int k = 0; k < 25; k++) begin
      logic [7:0] code;
      if ($urandom_range(0, 1) == 0)
        code = 8'($urandom_range(1, 8'h83));
      else
        case ($urandom_range(0, 3))
          0: code = 8'h1C;
          1: code = 8'h5A;
          2: code = 8'h29;
          default: code = 8'h66;
        endcase
      if ($urandom_range(0, 2) == 0) send_byte(8'hE0);
      if ($urandom_range(0, 2) == 0) send_byte(8'hF0);
      send_byte(code);
    end
    repeat (20) @(negedge clk);
    nexp = exp_q.size();
    chk("rnd_n", got.size(), nexp);
    for (int i = 0; i < nexp && i < got.size(); i++)
      chk($sformatf("rnd%0d", i), got[i], exp_q[i]);
    chk("rnd_errcnt", err_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
